// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of a single memory data port.
//   m0_* : core data request   (valid/addr/wdata/we in, ready/rdata/err out)
//   m1_* : DMA/loader request  (same shape as m0)
//   s_*  : request to memory (valid/addr/wdata/we out, ready/rdata in)
//   grant_o : one-hot owner of the memory port (bit0 = m0, bit1 = m1)
// IDLE/BUSY FSM with a registered grant and a round-robin pointer that is
// handed to the other master on every completion or timeout. Request fields
// are never buffered; the granted master's inputs are steered straight
// through to the memory port while BUSY.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WORD_WIDTH-1:0] m0_wdata_i,
  input  logic [3:0]            m0_we_i,
  output logic                  m0_ready_o,
  output logic [WORD_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_valid_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WORD_WIDTH-1:0] m1_wdata_i,
  input  logic [3:0]            m1_we_i,
  output logic                  m1_ready_o,
  output logic [WORD_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,
  output logic                  s_valid_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [WORD_WIDTH-1:0] s_wdata_o,
  output logic [3:0]            s_we_o,
  input  logic                  s_ready_i,
  input  logic [WORD_WIDTH-1:0] s_rdata_i,
  output logic [1:0]            grant_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  // Per-master views as packed arrays so the steering is a plain index.
  logic [1:0]                 m_valid;
  logic [1:0][ADDR_WIDTH-1:0] m_addr;
  logic [1:0][WORD_WIDTH-1:0] m_wdata;
  logic [1:0][3:0]            m_we;
  logic [1:0]                 m_ready, m_err;
  logic [1:0][WORD_WIDTH-1:0] m_rdata;

  assign m_valid = {m1_valid_i, m0_valid_i};
  assign m_addr  = {m1_addr_i,  m0_addr_i};
  assign m_wdata = {m1_wdata_i, m0_wdata_i};
  assign m_we    = {m1_we_i,    m0_we_i};

  assign m0_ready_o = m_ready[0];
  assign m1_ready_o = m_ready[1];
  assign m0_err_o   = m_err[0];
  assign m1_err_o   = m_err[1];
  assign m0_rdata_o = m_rdata[0];
  assign m1_rdata_o = m_rdata[1];

  logic sel;      // granted master index (grant is one-hot, bit1 => m1)
  logic sel_vld;  // granted master still requesting
  logic tmo;      // last allowed BUSY cycle passes without memory ready

  assign sel     = grant_q[1];
  assign sel_vld = m_valid[sel];
  assign tmo     = (cnt_q == TO_LAST) && !s_ready_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|m_valid) begin
          state_d = BUSY;
          cnt_d   = 8'd0;
          if (&m_valid) grant_d = ptr_q ? 2'b10 : 2'b01;
          else          grant_d = m_valid[1] ? 2'b10 : 2'b01;
        end
      end
      BUSY: begin
        if (!sel_vld) begin
          // Master abandoned the request: drop it, keep the pointer.
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (s_ready_i || tmo) begin
          state_d = IDLE;
          grant_d = 2'b00;
          ptr_d   = ~sel;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Output logic
  always_comb begin
    s_valid_o = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_we_o    = 4'b0000;
    grant_o   = 2'b00;
    m_ready   = 2'b00;
    m_err     = 2'b00;
    m_rdata   = '0;
    if (state_q == BUSY) begin
      grant_o   = grant_q;
      s_valid_o = sel_vld;
      s_addr_o  = m_addr[sel];
      s_wdata_o = m_wdata[sel];
      s_we_o    = m_we[sel];
      // Memory completion wins over a coincident timeout.
      if (sel_vld && s_ready_i) begin
        m_ready[sel] = 1'b1;
        m_rdata[sel] = s_rdata_i;
      end else if (sel_vld && tmo) begin
        m_ready[sel] = 1'b1;
        m_err[sel]   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (TIMEOUT=4). Inputs are driven 1 time unit
// after each rising edge; outputs are sampled 1 unit later.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_valid_i = 1'b0, m1_valid_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [WW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic [3:0]    m0_we_i = '0, m1_we_i = '0;
  logic          m0_ready_o, m1_ready_o, m0_err_o, m1_err_o;
  logic [WW-1:0] m0_rdata_o, m1_rdata_o;
  logic          s_valid_o;
  logic [AW-1:0] s_addr_o;
  logic [WW-1:0] s_wdata_o;
  logic [3:0]    s_we_o;
  logic          s_ready_i = 1'b0;
  logic [WW-1:0] s_rdata_i = '0;
  logic [1:0]    grant_o;

  dmem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_we_i(m0_we_i),
    .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_we_i(m1_we_i),
    .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_we_o(s_we_o),
    .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] cont_g [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    int n;
    // Reset state
    #2;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_svalid", 32'(s_valid_o), 32'd0);
    chk("rst_m0rdy", 32'(m0_ready_o), 32'd0);
    #10 rst_n = 1'b1;

    // Single read, m0, memory ready in cycle 3
    cyc();
    m0_valid_i = 1'b1; m0_addr_i = 32'h100; m0_we_i = 4'h0;
    #1 chk("rd_c0_grant", 32'(grant_o), 32'd0);
    chk("rd_c0_svalid", 32'(s_valid_o), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 3) begin s_ready_i = 1'b1; s_rdata_i = 32'hDEADBEEF; end
      #1;
      chk("rd_svalid", 32'(s_valid_o), 32'd1);
      chk("rd_saddr", s_addr_o, 32'h100);
      chk("rd_grant", 32'(grant_o), 32'd1);
      chk("rd_m0rdy", 32'(m0_ready_o), (c == 3) ? 32'd1 : 32'd0);
      chk("rd_m1rdy", 32'(m1_ready_o), 32'd0);
    end
    chk("rd_rdata", m0_rdata_o, 32'hDEADBEEF);
    chk("rd_err", 32'(m0_err_o), 32'd0);
    chk("rd_m1rdata", m1_rdata_o, 32'd0);
    cyc();
    m0_valid_i = 1'b0; s_ready_i = 1'b0; s_rdata_i = '0;
    #1 chk("rd_c4_grant", 32'(grant_o), 32'd0);
    chk("rd_c4_m0rdy", 32'(m0_ready_o), 32'd0);

    // Contention from a fresh reset, memory always ready
    cyc();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m0_valid_i = 1'b1; m1_valid_i = 1'b1; s_ready_i = 1'b1; s_rdata_i = 32'hA5A50000;
    #1 chk("ct_idle", 32'(grant_o), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(); #1;
      chk("ct_grant", 32'(grant_o), 32'(cont_g[i]));
      chk("ct_m0rdy", 32'(m0_ready_o), 32'(cont_g[i][0]));
      chk("ct_m1rdy", 32'(m1_ready_o), 32'(cont_g[i][1]));
    end

    // Only m1 requests: granted each time regardless of pointer
    cyc();
    m0_valid_i = 1'b0;
    #1 chk("sr_idle", 32'(grant_o), 32'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      if (m1_ready_o) n++;
      chk("sr_grant", 32'(grant_o), (i % 2 == 0) ? 32'd2 : 32'd0);
      chk("sr_m0rdy", 32'(m0_ready_o), 32'd0);
    end
    cyc();
    m1_valid_i = 1'b0; s_ready_i = 1'b0; s_rdata_i = '0;
    #1 chk("sr_pulses", 32'(n), 32'd3);

    // Timeout: write, memory never ready
    cyc();
    m0_valid_i = 1'b1; m0_addr_i = 32'h200; m0_wdata_i = 32'hCAFEF00D; m0_we_i = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      cyc(); #1;
      chk("to_grant", 32'(grant_o), 32'd1);
      chk("to_swe", 32'(s_we_o), 32'hF);
      chk("to_m0rdy", 32'(m0_ready_o), (c == 4) ? 32'd1 : 32'd0);
      chk("to_m0err", 32'(m0_err_o), (c == 4) ? 32'd1 : 32'd0);
    end
    chk("to_rdata", m0_rdata_o, 32'd0);
    chk("to_swdata", s_wdata_o, 32'hCAFEF00D);
    cyc();
    m0_valid_i = 1'b0;
    #1 chk("to_c5_grant", 32'(grant_o), 32'd0);

    // Same, but memory ready in the timeout cycle
    cyc();
    m0_valid_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 4) begin s_ready_i = 1'b1; s_rdata_i = 32'h12345678; end
      #1;
      chk("tr_m0rdy", 32'(m0_ready_o), (c == 4) ? 32'd1 : 32'd0);
      chk("tr_m0err", 32'(m0_err_o), 32'd0);
    end
    chk("tr_rdata", m0_rdata_o, 32'h12345678);
    cyc();
    m0_valid_i = 1'b0; s_ready_i = 1'b0; s_rdata_i = '0;
    #1 chk("tr_c5_grant", 32'(grant_o), 32'd0);

    // Valid drop by m1 (pointer now favours m1)
    cyc();
    m1_valid_i = 1'b1; m1_addr_i = 32'h300;
    cyc(); #1;
    chk("vd_c1_grant", 32'(grant_o), 32'd2);
    chk("vd_c1_saddr", s_addr_o, 32'h300);
    cyc();
    m1_valid_i = 1'b0;
    #1 chk("vd_c2_svalid", 32'(s_valid_o), 32'd0);
    chk("vd_c2_m1rdy", 32'(m1_ready_o), 32'd0);
    cyc(); #1;
    chk("vd_c3_grant", 32'(grant_o), 32'd0);
    m0_valid_i = 1'b1; m1_valid_i = 1'b1;
    cyc();
    s_ready_i = 1'b1;
    #1 chk("vd_ptr_grant", 32'(grant_o), 32'd2);
    chk("vd_ptr_m1rdy", 32'(m1_ready_o), 32'd1);
    chk("vd_ptr_m0rdy", 32'(m0_ready_o), 32'd0);
    cyc();
    m0_valid_i = 1'b0; m1_valid_i = 1'b0; s_ready_i = 1'b0;

    // Asynchronous reset in the middle of a BUSY transfer
    cyc();
    m0_valid_i = 1'b1; m0_addr_i = 32'h400;
    cyc(); #1;
    chk("ar_busy_grant", 32'(grant_o), 32'd1);
    s_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("ar_svalid", 32'(s_valid_o), 32'd0);
    chk("ar_grant", 32'(grant_o), 32'd0);
    chk("ar_m0rdy", 32'(m0_ready_o), 32'd0);
    s_ready_i = 1'b0;
    #1 rst_n = 1'b1;
    #1 chk("ar_rel_grant", 32'(grant_o), 32'd0);
    cyc(); #1;
    chk("ar_regrant", 32'(grant_o), 32'd1);
    chk("ar_regrant_sv", 32'(s_valid_o), 32'd1);
    s_ready_i = 1'b1;
    #1 chk("ar_done", 32'(m0_ready_o), 32'd1);
    cyc();
    m0_valid_i = 1'b0; s_ready_i = 1'b0;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports SHALL be ADDR_WIDTH bits.
REQ-002 Parameter WORD_WIDTH, default 32, data width of all ports SHALL be WORD_WIDTH bits.
REQ-003 Parameter TIMEOUT, default 255, range 1..255; SHALL set the maximum number of BUSY cycles before the arbiter aborts a transfer.
REQ-004 One clock; reset is asynchronous and active-low. Ports: clk input 1, the single clock; rst_n input 1, the asynchronous active-low reset.
REQ-005 Ports m0_valid_i (1), m0_addr_i (ADDR_WIDTH), m0_wdata_i (WORD_WIDTH), m0_we_i (4): inputs, the core data request, and m1_* with identical widths are inputs, the DMA/loader request.
REQ-006 Ports m0_ready_o (1), m0_rdata_o (WORD_WIDTH), m0_err_o (1): outputs, the m0 completion, read data and abort flag, and m1_* with identical widths are outputs with the same meaning for m1.
REQ-007 Ports s_valid_o (1), s_addr_o (ADDR_WIDTH), s_wdata_o (WORD_WIDTH), s_we_o (4): outputs, the request to the memory data port.
REQ-008 Ports s_ready_i (1): input, the memory completion strobe, and s_rdata_i (WORD_WIDTH): input, the read data, valid while s_ready_i=1.
REQ-009 Port grant_o (2): output, one-hot owner of the memory port; bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-010 Masters SHALL hold valid, addr, wdata and we stable from assertion until their ready=1; the arbiter SHALL NOT buffer request fields.
REQ-011 FSM states SHALL be IDLE and BUSY, with a registered grant and a registered 1-bit priority pointer (0 = m0 preferred).
REQ-012 IDLE: s_valid_o=0, s_addr_o=0, s_wdata_o=0, s_we_o=0, grant_o=00, all m*_ready_o=0.
REQ-013 IDLE with exactly one m*_valid_i=1 SHALL grant that master and enter BUSY on the next edge.
REQ-014 IDLE with both valid SHALL grant the master selected by the priority pointer.
REQ-015 BUSY: s_* SHALL be driven combinationally from the granted master's inputs, and grant_o SHALL show that master.
REQ-016 Arbitration latency SHALL be exactly 1 cycle: valid at edge N gives s_valid_o=1 from cycle N+1.
REQ-017 BUSY with s_ready_i=1: the granted master's ready SHALL be 1 that cycle with rdata = s_rdata_i and err = 0.
REQ-018 On that completion the FSM SHALL return to IDLE, and the priority pointer SHALL point to the non-granted master.
REQ-019 The non-granted master's ready and err SHALL be 0 in every cycle, and its rdata SHALL be 0.
REQ-020 A timeout counter (8 bits) SHALL clear on entry to BUSY and increment each BUSY cycle with s_ready_i=0.
REQ-021 Timeout: when the counter equals TIMEOUT-1 and s_ready_i=0, the granted master's ready and err SHALL be 1 for one cycle, with rdata=0.
REQ-022 After a timeout the FSM SHALL go to IDLE and the pointer SHALL advance as in REQ-018.
REQ-023 If s_ready_i=1 in the timeout cycle, normal completion (REQ-017) SHALL take precedence and err SHALL be 0.
REQ-024 If the granted master drops valid in BUSY (protocol violation), s_valid_o SHALL follow it to 0 that cycle, no ready SHALL be given, and the FSM SHALL return to IDLE next edge with the pointer unchanged.
REQ-025 A master completing at edge N and still requesting SHALL be eligible in IDLE at cycle N+1. There is no back-to-back BUSY; one IDLE cycle separates transfers.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, grant 00, pointer 0, counter 0, and all outputs 0, independent of clk.
REQ-027 A transfer in flight at reset SHALL be dropped without a ready; after rst_n rises, arbitration SHALL restart per REQ-013/014.

Verification
REQ-028 Reset: assert rst_n=0 mid-BUSY with m0_valid_i=1 -> s_valid_o, grant_o, m0_ready_o go 0 before the next clk edge; after release, m0 is regranted at 1-cycle latency.
REQ-029 Single read: m0_valid_i=1 at cycle 0, addr 0x100, we 0; s_ready_i=1 at cycle 3, s_rdata_i 0xDEADBEEF -> s_valid_o=1 and s_addr_o=0x100 in cycles 1..3; m0_ready_o=1 and m0_rdata_o=0xDEADBEEF in cycle 3 only; m1_ready_o=0 throughout.
REQ-030 Contention: both masters valid continuously from reset, memory ready in the 1st BUSY cycle -> grant sequence 01,00,10,00,01,00,10 (strict alternation).
REQ-031 Single requester: only m1 valid, 3 consecutive transfers -> m1 granted each time despite pointer state; exactly 3 m1_ready_o pulses.
REQ-032 Timeout: TIMEOUT=4, m0 write we=1111 at cycle 0, s_ready_i held 0 -> BUSY in cycles 1..4; m0_ready_o=1 and m0_err_o=1 in cycle 4; IDLE in cycle 5. Repeat with s_ready_i=1 in cycle 4 -> err=0.
REQ-033 Valid drop: m1 granted, m1_valid_i falls in the 2nd BUSY cycle -> s_valid_o=0 that cycle, no m1_ready_o, IDLE next cycle, pointer unchanged.
